// File: rtl/xbf_delay_sum.sv
// Multichannel delay-and-sum beamformer: per-channel programmable sample delay,
// full-precision sum, two-stage valid/ready pipeline.
module xbf_delay_sum #(
    parameter int NCH    = 4,
    parameter int DW     = 16,
    parameter int MAXDLY = 16,
    parameter int DLYW   = $clog2(MAXDLY),
    parameter int OW     = DW + $clog2(NCH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   cfg_wr,
    input  logic [$clog2(NCH)-1:0] cfg_ch,
    input  logic [DLYW:0]          cfg_dly,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [NCH*DW-1:0]      s_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [OW-1:0]          m_data
);
    localparam int CHW = $clog2(NCH);
    localparam logic [CHW:0] NCH_L = (CHW+1)'(NCH);

    logic              en;
    logic              accept;
    logic [DLYW-1:0]   dly_q [NCH];
    logic [DLYW-1:0]   dly_d [NCH];
    logic [DLYW-1:0]   wr_ptr_q, wr_ptr_d;
    logic              s1_valid_q, s1_valid_d;
    logic              m_valid_q, m_valid_d;
    logic [OW-1:0]     m_data_q, m_data_d;
    logic [OW-1:0]     beam_sum;
    logic [NCH*DW-1:0] tap_w;

    assign en      = !m_valid_q || m_ready;
    assign s_ready = en && !clr;
    assign accept  = s_valid && s_ready;

    // MAXDLY is a power of two, so the extra top bit alone flags an over-range request.
    always_comb begin
        dly_d = dly_q;
        if (cfg_wr && ({1'b0, cfg_ch} < NCH_L)) begin
            dly_d[cfg_ch] = cfg_dly[DLYW] ? {DLYW{1'b1}} : cfg_dly[DLYW-1:0];
        end
    end

    always_comb begin
        beam_sum = '0;
        for (int i = 0; i < NCH; i++) begin
            beam_sum = beam_sum + {{(OW-DW){tap_w[i*DW+DW-1]}}, tap_w[i*DW +: DW]};
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        s1_valid_d = s1_valid_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        if (clr) begin
            wr_ptr_d   = '0;
            s1_valid_d = 1'b0;
            m_valid_d  = 1'b0;
        end else if (en) begin
            s1_valid_d = accept;
            m_valid_d  = s1_valid_q;
            m_data_d   = beam_sum;
            if (accept) begin
                wr_ptr_d = wr_ptr_q + DLYW'(1);
            end
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [DW-1:0]   mem_q [MAXDLY];
        logic [DW-1:0]   mem_d [MAXDLY];
        logic [DW-1:0]   tap_q, tap_d;
        logic [DW-1:0]   sample;
        logic [DLYW-1:0] rd_ptr;

        assign sample = s_data[gi*DW +: DW];
        assign rd_ptr = wr_ptr_q - dly_q[gi];

        // The tap reads the stored history before this cycle's write lands.
        always_comb begin
            mem_d = mem_q;
            tap_d = tap_q;
            if (clr) begin
                for (int k = 0; k < MAXDLY; k++) begin
                    mem_d[k] = '0;
                end
            end else if (accept) begin
                mem_d[wr_ptr_q] = sample;
                tap_d = (dly_q[gi] == '0) ? sample : mem_q[rd_ptr];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < MAXDLY; k++) begin
                    mem_q[k] <= '0;
                end
                tap_q <= '0;
            end else begin
                mem_q <= mem_d;
                tap_q <= tap_d;
            end
        end

        assign tap_w[gi*DW +: DW] = tap_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                dly_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            s1_valid_q <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
        end else begin
            dly_q      <= dly_d;
            wr_ptr_q   <= wr_ptr_d;
            s1_valid_q <= s1_valid_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;

endmodule

// File: tb/tb_xbf_delay_sum.sv
// Bench for xbf_delay_sum: table vectors, directed corner sequences and a
// randomized run scored against a history-based model of the beamformer.
module tb_xbf_delay_sum;
    localparam int NCH = 4, DW = 16, MAXDLY = 16, DLYW = 4, OW = 18;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0;
    logic          cfg_wr = 1'b0;
    logic [1:0]    cfg_ch = '0;
    logic [DLYW:0] cfg_dly = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [NCH*DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [OW-1:0] m_data;

    xbf_delay_sum #(.NCH(NCH), .DW(DW), .MAXDLY(MAXDLY)) dut (
        .clk(clk), .rst(rst), .clr(clr), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_dly(cfg_dly), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int dly_m [NCH];
    int hist [NCH][$];     // samples accepted since the last reset/clr, per channel
    int exp_q [$];         // beam values owed to the output, oldest first
    int outs [$];          // beam values actually transferred
    bit acc;
    bit hold_prev = 1'b0;
    int data_prev = 0;

    typedef struct { int x0; int x1; int x2; int x3; int sum; } vec_t;
    vec_t tbl [5];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic set_data(input int a0, input int a1, input int a2, input int a3);
        s_data = {DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
    endtask

    // One clock: score the current cycle, advance the model, then step past the edge.
    task automatic cycle();
        bit exp_srdy;
        int sum, x, d, n;
        #1;
        exp_srdy = (!m_valid || m_ready) && !clr;
        check("s_ready", int'(s_ready), int'(exp_srdy));
        if (hold_prev) begin
            check("hold_valid", int'(m_valid), 1);
            check("hold_data", int'($signed(m_data)), data_prev);
        end
        if (m_valid && m_ready) begin
            outs.push_back(int'($signed(m_data)));
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=%0d required=none", $signed(m_data));
            end else begin
                check("beam", int'($signed(m_data)), exp_q.pop_front());
            end
        end
        acc = s_valid && exp_srdy;
        if (acc) begin
            sum = 0;
            for (int ch = 0; ch < NCH; ch++) begin
                x = int'($signed(s_data[ch*DW +: DW]));
                d = dly_m[ch];
                n = hist[ch].size();
                if (d == 0) sum += x;
                else if (n >= d) sum += hist[ch][n-d];
                hist[ch].push_back(x);
            end
            exp_q.push_back(sum);
        end
        if (clr) begin
            exp_q.delete();
            for (int ch = 0; ch < NCH; ch++) hist[ch].delete();
        end
        if (cfg_wr) dly_m[cfg_ch] = (int'(cfg_dly) >= MAXDLY) ? MAXDLY - 1 : int'(cfg_dly);
        hold_prev = m_valid && !m_ready && !clr;
        data_prev = int'($signed(m_data));
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int a0, input int a1, input int a2, input int a3);
        int g = 0;
        set_data(a0, a1, a2, a3);
        s_valid = 1'b1;
        do begin
            cycle();
            g++;
        end while (!acc && g < 50);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=%0d cycles required=accept", g);
        end
        s_valid = 1'b0;
    endtask

    task automatic cfg(input int ch, input int d);
        cfg_wr  = 1'b1;
        cfg_ch  = 2'(ch);
        cfg_dly = 5'(d);
        cycle();
        cfg_wr  = 1'b0;
    endtask

    task automatic flush();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        m_ready = 1'b1;
        while ((exp_q.size() != 0 || m_valid) && g < 100) begin
            cycle();
            g++;
        end
        if (g >= 100) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_sent, stall;
        bit seen;
        int exp2 [6];
        exp2 = '{0, 0, 0, 1000, 0, 0};
        for (int ch = 0; ch < NCH; ch++) dly_m[ch] = 0;

        tbl[0] = '{100, 100, 100, 100, 400};
        tbl[1] = '{-32768, -32768, -32768, -32768, -131072};
        tbl[2] = '{32767, 32767, 32767, 32767, 131068};
        tbl[3] = '{1000, -1, -999, 0, 0};
        tbl[4] = '{-5, 10, -20, 40, 25};

        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_data", int'(m_data), 0);
        check("rst_s_ready", int'(s_ready), 1);

        // Single vectors, exact two-cycle latency and a one-cycle valid pulse.
        for (int i = 0; i < 5; i++) begin
            set_data(tbl[i].x0, tbl[i].x1, tbl[i].x2, tbl[i].x3);
            s_valid = 1'b1;
            cycle();
            check("tbl_accept", int'(acc), 1);
            s_valid = 1'b0;
            check("tbl_lat1_valid", int'(m_valid), 0);
            cycle();
            check("tbl_lat2_valid", int'(m_valid), 1);
            check("tbl_sum", int'($signed(m_data)), tbl[i].sum);
            cycle();
            check("tbl_lat3_valid", int'(m_valid), 0);
            cycle();
        end

        // Impulse through a three-sample delay on channel 0.
        cfg(0, 3);
        flush();
        outs.delete();
        for (int i = 0; i < 6; i++) send(i == 0 ? 1000 : 0, 0, 0, 0);
        drain();
        check("dly3_count", outs.size(), 6);
        for (int k = 0; k < 6 && k < outs.size(); k++) check("dly3_seq", outs[k], exp2[k]);

        // Ramp with a five-cycle output stall right at the first result.
        cfg(0, 0);
        flush();
        outs.delete();
        n_sent = 0;
        seen = 1'b0;
        stall = 0;
        for (int c = 0; c < 60 && !(n_sent == 8 && exp_q.size() == 0 && !m_valid); c++) begin
            s_valid = (n_sent < 8);
            set_data(n_sent + 1, n_sent + 1, n_sent + 1, n_sent + 1);
            if (!seen && m_valid) begin
                seen = 1'b1;
                stall = 5;
            end
            m_ready = (stall == 0);
            if (stall > 0) begin
                #1;
                check("stall_data", int'($signed(m_data)), 4);
                check("stall_s_ready", int'(s_ready), 0);
            end
            cycle();
            if (acc) n_sent++;
            if (stall > 0) stall--;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        check("ramp_sent", n_sent, 8);
        check("ramp_count", outs.size(), 8);
        for (int k = 0; k < outs.size(); k++) check("ramp_seq", outs[k], 4 * (k + 1));

        // Over-range delay clamps to MAXDLY-1. With four channels every 2-bit
        // channel index is in range, so an ignored out-of-range write cannot be driven here.
        cfg(2, 20);
        flush();
        outs.delete();
        send(0, 0, 7, 0);
        for (int i = 0; i < 20; i++) send(0, 0, 0, 0);
        drain();
        check("clamp_count", outs.size(), 21);
        for (int k = 0; k < outs.size(); k++) check("clamp_seq", outs[k], k == 15 ? 7 : 0);

        // clr drops in-flight data and the concurrent sample but keeps delays.
        cfg(1, 4);
        cfg(2, 0);
        flush();
        send(0, 50, 0, 0);
        send(0, 50, 0, 0);
        clr = 1'b1;
        s_valid = 1'b1;
        set_data(0, 50, 0, 0);
        #1;
        check("clr_s_ready", int'(s_ready), 0);
        cycle();
        clr = 1'b0;
        s_valid = 1'b0;
        check("clr_m_valid", int'(m_valid), 0);
        outs.delete();
        for (int i = 0; i < 8; i++) send(0, 0, 0, 0);
        drain();
        check("clr_zero_count", outs.size(), 8);
        for (int k = 0; k < outs.size(); k++) check("clr_no_leak", outs[k], 0);
        flush();
        outs.delete();
        send(0, 9, 0, 0);
        for (int i = 0; i < 5; i++) send(0, 0, 0, 0);
        drain();
        check("clr_keep_count", outs.size(), 6);
        for (int k = 0; k < outs.size(); k++) check("clr_keep_dly", outs[k], k == 4 ? 9 : 0);

        // Randomized traffic, config writes and flushes against the model.
        for (int c = 0; c < 3000; c++) begin
            s_valid = ($urandom_range(0, 9) < 8);
            s_data  = {$urandom, $urandom};
            m_ready = ($urandom_range(0, 3) != 0);
            cfg_wr  = ($urandom_range(0, 19) == 0);
            cfg_ch  = 2'($urandom_range(0, 3));
            cfg_dly = 5'($urandom_range(0, 31));
            clr     = ($urandom_range(0, 49) == 0);
            cycle();
        end
        s_valid = 1'b0;
        cfg_wr = 1'b0;
        clr = 1'b0;
        drain();
        check("rand_drained", exp_q.size(), 0);

        // Asynchronous reset mid-stream clears the pipeline and the delay registers.
        cfg(0, 5);
        send(1, 2, 3, 4);
        send(5, 6, 7, 8);
        send(9, 10, 11, 12);
        check("pre_rst_valid", int'(m_valid), 1);
        rst = 1'b1;
        #1;
        check("arst_m_valid", int'(m_valid), 0);
        check("arst_m_data", int'(m_data), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
            dly_m[ch] = 0;
            hist[ch].delete();
        end
        exp_q.delete();
        hold_prev = 1'b0;
        outs.delete();
        send(11, 0, 0, 0);
        send(0, 0, 0, 0);
        drain();
        check("rst_dly_count", outs.size(), 2);
        if (outs.size() > 0) check("rst_dly_cleared", outs[0], 11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/xbf_delay_sum.md
Name: xbf_delay_sum

Overview:
- Parametrised multichannel delay-and-sum beamformer for the XBF receive path.
- Accepts one packed sample vector per handshake, with NCH channels of signed DW-bit samples.
- Delays each channel by a run-time programmable integer number of samples, from 0 to MAXDLY-1.
- Sums the delayed samples at full precision and emits one beam sample per input sample on a valid/ready stream.

Parameters:
- NCH, 4, number of input channels (≥2).
- DW, 16, signed sample width per channel.
- MAXDLY, 16, delay-line depth per channel; must be a power of 2 and ≥2.
- DLYW, $clog2(MAXDLY), width of the delay config field.
- OW, DW+$clog2(NCH), output width.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous flush of delay history and pipeline.
- cfg_wr  in  1  delay-register write strobe.
- cfg_ch  in  $clog2(NCH)  channel index for the write.
- cfg_dly  in  DLYW+1  requested delay in samples.
- s_valid  in  1  input sample vector valid.
- s_ready  out  1  input accepted when s_valid && s_ready.
- s_data  in  NCH*DW  packed samples; channel i occupies bits [i*DW +: DW].
- m_valid  out  1  beam output valid.
- m_ready  in  1  downstream ready.
- m_data  out  OW  signed beam sum.

Behaviour:
- Reset values:
  - m_valid=0, m_data=0.
  - All delay registers=0, all delay-line memories=0, write pointer=0.
  - Stage-1 valid=0.
  - s_ready=1 once rst deasserts.
- Pipeline enable: en = !m_valid | m_ready; s_ready = en & !clr.
- Accept cycle (s_valid & s_ready):
  - The channel i sample is written to mem_i[wr_ptr]; wr_ptr increments modulo MAXDLY (natural wrap).
  - In the same cycle, stage 1 registers tap_i:
    - tap_i = s_data channel i when dly_i=0;
    - tap_i = mem_i[(wr_ptr - dly_i) mod MAXDLY] otherwise, i.e. the sample accepted dly_i handshakes earlier.
  - Stage-1 valid is set.
- Stage 2, on en: m_data = sum of all tap_i, each sign-extended to OW bits; m_valid = stage-1 valid.
  - No overflow is possible and no saturation is applied.
- Latency: accept in cycle t gives m_valid in cycle t+2 when unstalled. Throughput is one sample per clock.
- Backpressure:
  - While m_valid=1 and m_ready=0, en=0: both stages, wr_ptr and the memories hold.
  - m_data is stable and no input is accepted.
- Bubbles: when en=1 and no input is accepted, stage-1 valid is cleared and propagates as m_valid=0.
- Delay is counted in accepted samples, not clocks. Before a channel has history, its taps read the 0 left by reset or clr.
- Config:
  - A cfg_wr write loads dly[cfg_ch] on the next clock edge and applies from the next accepted sample onward.
  - cfg_dly ≥ MAXDLY is clamped to MAXDLY-1.
  - cfg_ch ≥ NCH is ignored.
  - Config writes proceed regardless of stall or clr.
  - A write and a sample accept in the same cycle: the sample uses the old delay.
- clr, synchronous, with priority over everything except rst:
  - Next edge: memories=0, wr_ptr=0, stage-1 valid=0, m_valid=0.
  - Delay registers are retained.
  - s_ready=0 during clr; a concurrent s_valid sample is dropped.
- rst mid-stream: immediately forces the reset values, including clearing the delay registers.
- Memory: may be flops or distributed RAM, but must read the pre-write value at wr_ptr-dly (read-before-write). No RAM primitives that need clock-enable tricks.

Test Plan:
All scenarios use NCH=4, DW=16, MAXDLY=16, OW=18.
1. Reset, then one vector with all channels = 100, m_ready=1 → exactly one m_valid pulse, 2 cycles after the accept, with m_data=400; s_ready=1 throughout.
2. dly0=3, others 0; ch0 impulse of 1000 at sample 0, all other samples and channels 0, 6 samples back-to-back → m_data sequence 0,0,0,1000,0,0.
3. All channels = -32768 for one sample → m_data = -131072 (18'h20000), no wrap. Then all channels = 32767 → 131068.
4. Ramp 1..8 on all channels, dly=0; hold m_ready=0 for 5 cycles after the first output → m_data held at 4, s_ready=0, no loss; outputs read 4,8,...,32 in order.
5. cfg_dly=20 on ch2 → clamps to 15; ch2 impulse of 7 at sample 0, then 20 zero samples → output index 15 = 7, all others 0. cfg_ch=5 write → no change to any delay.
6. dly1=4; send 2 samples with ch1=50, assert clr for 1 cycle with s_valid=1, then send zeros → m_valid drops next cycle, clr-cycle sample is dropped, no 50 appears at any later output; dly1 is still 4, verified by a later impulse.
